// File: rtl/i2c_pkg.sv
`default_nettype none
// ============================================================================
// Module      : i2c_pkg
// Description : Shared types and constants for the I2C target responder.
// Revision    : 1.0 - initial release
// ============================================================================
package i2c_pkg;

  // Target FSM state codes; the values are shown directly on the debug LEDs.
  typedef enum logic [7:0] {
    ST_IDLE      = 8'h00,
    ST_ADDR      = 8'h01,
    ST_ADDR_ACK  = 8'h02,
    ST_WRITE     = 8'h10,
    ST_WRITE_ACK = 8'h11,
    ST_READ      = 8'h20,
    ST_READ_ACK  = 8'h21
  } state_t;

  localparam logic I2C_ACK  = 1'b0;
  localparam logic I2C_NACK = 1'b1;

  localparam logic [6:0] I2C_DEFAULT_ADDR = 7'h50;

endpackage
`default_nettype wire

// File: rtl/i2c_sync_edge.sv
`default_nettype none
// ============================================================================
// Module      : i2c_sync_edge
// Description : Synchronizes SCL/SDA into the system clock domain and derives
//               SCL edges plus START/STOP bus conditions.
// Revision    : 1.0 - initial release
// ============================================================================
module i2c_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic iClk,
  input  logic iRst,
  input  logic iSCL,
  input  logic iSDA,
  output logic oSDA,
  output logic oSCL_Rise,
  output logic oSCL_Fall,
  output logic oStart,
  output logic oStop
);

  // Chains reset to 1 (idle bus level) so reset release creates no false edges.
  logic [SYNC_STAGES-1:0] r_scl_sync;
  logic [SYNC_STAGES-1:0] r_sda_sync;
  logic                   r_scl_d;
  logic                   r_sda_d;
  logic                   w_scl;
  logic                   w_sda;

  assign w_scl = r_scl_sync[SYNC_STAGES-1];
  assign w_sda = r_sda_sync[SYNC_STAGES-1];

  // Synchronizer chains and one-cycle history for edge detection.
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      r_scl_sync <= '1;
      r_sda_sync <= '1;
      r_scl_d    <= 1'b1;
      r_sda_d    <= 1'b1;
    end else begin
      r_scl_sync <= {r_scl_sync[SYNC_STAGES-2:0], iSCL};
      r_sda_sync <= {r_sda_sync[SYNC_STAGES-2:0], iSDA};
      r_scl_d    <= w_scl;
      r_sda_d    <= w_sda;
    end
  end

  // START/STOP require SCL stable high across the SDA transition.
  assign oSDA      = w_sda;
  assign oSCL_Rise = w_scl & ~r_scl_d;
  assign oSCL_Fall = ~w_scl & r_scl_d;
  assign oStart    = w_scl & r_scl_d & r_sda_d & ~w_sda;
  assign oStop     = w_scl & r_scl_d & ~r_sda_d & w_sda;

endmodule
`default_nettype wire

// File: rtl/i2c_slave.sv
`default_nettype none
// ============================================================================
// Module      : i2c_slave
// Description : I2C target with 7-bit address match, byte-wide write/read
//               user interface and open-drain SDA driver.
// Revision    : 1.0 - initial release
// ============================================================================
module i2c_slave
  import i2c_pkg::*;
#(
  parameter logic [6:0] SLAVE_ADDR  = I2C_DEFAULT_ADDR,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       iClk,
  input  logic       iRst,
  input  logic       iSCL,
  inout  wire        ioSDA,
  output logic [7:0] oRx_Data,
  output logic       oRx_Valid,
  input  logic [7:0] iTx_Data,
  output logic       oTx_Req,
  output logic       oRW,
  output logic       oBusy,
  output logic [7:0] oState
);

  localparam logic [7:0] c_ST_IDLE      = ST_IDLE;
  localparam logic [7:0] c_ST_ADDR      = ST_ADDR;
  localparam logic [7:0] c_ST_ADDR_ACK  = ST_ADDR_ACK;
  localparam logic [7:0] c_ST_WRITE     = ST_WRITE;
  localparam logic [7:0] c_ST_WRITE_ACK = ST_WRITE_ACK;
  localparam logic [7:0] c_ST_READ      = ST_READ;
  localparam logic [7:0] c_ST_READ_ACK  = ST_READ_ACK;

  logic       w_sda;
  logic       w_scl_rise;
  logic       w_scl_fall;
  logic       w_start;
  logic       w_stop;

  logic [7:0] r_state;
  logic [3:0] r_bit_cnt;
  logic [7:0] r_shift;
  logic [6:0] r_tx_shift;   // remaining read bits; bit 7 goes straight to SDA on load
  logic       r_sda_oe;
  logic [7:0] r_rx_data;
  logic       r_rx_valid;
  logic       r_tx_req;
  logic       r_rw;
  logic       r_busy;
  logic       r_nack;

  i2c_sync_edge #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync_edge (
    .iClk      (iClk),
    .iRst      (iRst),
    .iSCL      (iSCL),
    .iSDA      (ioSDA),
    .oSDA      (w_sda),
    .oSCL_Rise (w_scl_rise),
    .oSCL_Fall (w_scl_fall),
    .oStart    (w_start),
    .oStop     (w_stop)
  );

  // Open-drain: only ever pull low.
  assign ioSDA = r_sda_oe ? 1'b0 : 1'bz;

  assign oRx_Data  = r_rx_data;
  assign oRx_Valid = r_rx_valid;
  assign oTx_Req   = r_tx_req;
  assign oRW       = r_rw;
  assign oBusy     = r_busy;
  assign oState    = r_state;

  // Target FSM: STOP beats START beats SCL edges; SDA only moves after scl_fall.
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      r_state    <= c_ST_IDLE;
      r_bit_cnt  <= 4'd0;
      r_shift    <= 8'd0;
      r_tx_shift <= 7'd0;
      r_sda_oe   <= 1'b0;
      r_rx_data  <= 8'd0;
      r_rx_valid <= 1'b0;
      r_tx_req   <= 1'b0;
      r_rw       <= 1'b0;
      r_busy     <= 1'b0;
      r_nack     <= 1'b0;
    end else begin
      r_rx_valid <= 1'b0;
      r_tx_req   <= 1'b0;
      if (w_stop) begin
        r_state   <= c_ST_IDLE;
        r_sda_oe  <= 1'b0;
        r_busy    <= 1'b0;
        r_bit_cnt <= 4'd0;
      end else if (w_start) begin
        r_state   <= c_ST_ADDR;
        r_sda_oe  <= 1'b0;
        r_bit_cnt <= 4'd0;
      end else begin
        case (r_state)
          c_ST_ADDR: begin
            if (w_scl_rise) begin
              r_shift   <= {r_shift[6:0], w_sda};
              r_bit_cnt <= r_bit_cnt + 4'd1;
            end else if (w_scl_fall && r_bit_cnt == 4'd8) begin
              if (r_shift[7:1] == SLAVE_ADDR) begin
                r_sda_oe <= 1'b1;
                r_rw     <= r_shift[0];
                r_busy   <= 1'b1;
                r_tx_req <= r_shift[0];
                r_state  <= c_ST_ADDR_ACK;
              end else begin
                r_state  <= c_ST_IDLE;
              end
            end
          end
          c_ST_ADDR_ACK: begin
            if (w_scl_fall) begin
              r_bit_cnt <= 4'd0;
              if (r_rw) begin
                r_tx_shift <= iTx_Data[6:0];
                r_sda_oe   <= ~iTx_Data[7];
                r_state    <= c_ST_READ;
              end else begin
                r_sda_oe   <= 1'b0;
                r_state    <= c_ST_WRITE;
              end
            end
          end
          c_ST_WRITE: begin
            if (w_scl_rise) begin
              r_shift   <= {r_shift[6:0], w_sda};
              r_bit_cnt <= r_bit_cnt + 4'd1;
            end else if (w_scl_fall && r_bit_cnt == 4'd8) begin
              r_sda_oe   <= 1'b1;
              r_rx_data  <= r_shift;
              r_rx_valid <= 1'b1;
              r_state    <= c_ST_WRITE_ACK;
            end
          end
          c_ST_WRITE_ACK: begin
            if (w_scl_fall) begin
              r_sda_oe  <= 1'b0;
              r_bit_cnt <= 4'd0;
              r_state   <= c_ST_WRITE;
            end
          end
          c_ST_READ: begin
            if (w_scl_rise) begin
              r_bit_cnt <= r_bit_cnt + 4'd1;
            end else if (w_scl_fall) begin
              if (r_bit_cnt == 4'd8) begin
                r_sda_oe <= 1'b0;
                r_state  <= c_ST_READ_ACK;
              end else if (r_bit_cnt != 4'd0) begin
                r_sda_oe   <= ~r_tx_shift[6];
                r_tx_shift <= {r_tx_shift[5:0], 1'b0};
              end
            end
          end
          c_ST_READ_ACK: begin
            if (w_scl_rise) begin
              r_nack   <= (w_sda == I2C_NACK);
              r_tx_req <= (w_sda == I2C_ACK);
            end else if (w_scl_fall) begin
              r_bit_cnt <= 4'd0;
              if (r_nack) begin
                r_busy  <= 1'b0;
                r_state <= c_ST_IDLE;
              end else begin
                r_tx_shift <= iTx_Data[6:0];
                r_sda_oe   <= ~iTx_Data[7];
                r_state    <= c_ST_READ;
              end
            end
          end
          default: begin
            // IDLE ignores SCL activity until a START.
          end
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_i2c_slave.sv
`default_nettype none
// ============================================================================
// Module      : tb_i2c_slave
// Description : Bit-banged I2C master driving i2c_slave, with a scoreboard
//               for received write bytes and a responder for read requests.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_i2c_slave;

  localparam int Q = 50;  // quarter SCL period in ns (clk period 10 ns)

  logic       iClk = 1'b0;
  logic       iRst = 1'b1;
  logic       scl  = 1'b1;
  logic       m_oe = 1'b0;
  logic [7:0] iTx_Data = 8'd0;
  wire        sda_bus;
  logic [7:0] oRx_Data;
  logic       oRx_Valid;
  logic       oTx_Req;
  logic       oRW;
  logic       oBusy;
  logic [7:0] oState;

  int total = 0;
  int bad   = 0;
  int n_txreq = 0;
  logic [7:0] rxq[$];
  logic [7:0] txq[$];

  pullup (sda_bus);
  assign sda_bus = m_oe ? 1'b0 : 1'bz;

  always #5 iClk = ~iClk;

  i2c_slave dut (
    .iClk      (iClk),
    .iRst      (iRst),
    .iSCL      (scl),
    .ioSDA     (sda_bus),
    .oRx_Data  (oRx_Data),
    .oRx_Valid (oRx_Valid),
    .iTx_Data  (iTx_Data),
    .oTx_Req   (oTx_Req),
    .oRW       (oRW),
    .oBusy     (oBusy),
    .oState    (oState)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: score write bytes and answer read-data requests.
  initial begin
    forever begin
      @(negedge iClk);
      if (oRx_Valid) begin
        if (rxq.size() == 0) check("rx_unexpected", {24'd0, oRx_Data}, 32'hFFFF_FFFF);
        else check("rx_data", {24'd0, oRx_Data}, {24'd0, rxq.pop_front()});
      end
      if (oTx_Req) begin
        n_txreq++;
        iTx_Data = (txq.size() != 0) ? txq.pop_front() : 8'h00;
      end
    end
  end

  task automatic bus_start();
    m_oe = 1'b0; scl = 1'b1; #(2*Q);
    m_oe = 1'b1; #(2*Q);
    scl = 1'b0;
  endtask

  task automatic bus_rstart();
    #Q m_oe = 1'b0;
    #Q scl = 1'b1;
    #(2*Q) m_oe = 1'b1;
    #(2*Q) scl = 1'b0;
  endtask

  task automatic bus_stop();
    #Q m_oe = 1'b1;
    #Q scl = 1'b1;
    #(2*Q) m_oe = 1'b0;
    #(2*Q);
  endtask

  task automatic bit_out(input logic b);
    #Q m_oe = ~b;
    #Q scl = 1'b1;
    #(2*Q) scl = 1'b0;
  endtask

  task automatic bit_in(output logic b);
    #Q m_oe = 1'b0;
    #Q scl = 1'b1;
    #Q b = sda_bus;
    #Q scl = 1'b0;
  endtask

  task automatic write_byte(input string name, input logic [7:0] d, input logic exp_ack);
    logic a;
    for (int i = 7; i >= 0; i--) bit_out(d[i]);
    bit_in(a);
    check(name, {31'd0, a}, {31'd0, exp_ack});
  endtask

  task automatic read_byte(input string name, input logic [7:0] exp, input logic m_ack);
    logic [7:0] d;
    logic b;
    for (int i = 7; i >= 0; i--) begin
      bit_in(b);
      d[i] = b;
    end
    check(name, {24'd0, d}, {24'd0, exp});
    bit_out(m_ack);
  endtask

  initial begin
    logic [7:0] partial;
    repeat (4) @(posedge iClk);
    #1;
    check("rst_state", {24'd0, oState}, 32'h00);
    check("rst_outs", {20'd0, oRx_Data, oRx_Valid, oTx_Req, oRW, oBusy}, 32'h0);
    iRst = 1'b0;
    #(4*Q);

    // Plain write of one byte.
    bus_start();
    write_byte("t1_addr_ack", 8'hA0, 1'b0);
    rxq.push_back(8'h3C);
    write_byte("t1_data_ack", 8'h3C, 1'b0);
    check("t1_busy_before_stop", {31'd0, oBusy}, 32'd1);
    check("t1_rw", {31'd0, oRW}, 32'd0);
    bus_stop();
    check("t1_busy_after_stop", {31'd0, oBusy}, 32'd0);
    check("t1_state", {24'd0, oState}, 32'h00);
    check("t1_rxq_empty", rxq.size(), 32'd0);

    // Two-byte read, master NACKs the last one.
    n_txreq = 0;
    txq.push_back(8'h5A);
    txq.push_back(8'hC3);
    bus_start();
    write_byte("t2_addr_ack", 8'hA1, 1'b0);
    check("t2_rw", {31'd0, oRW}, 32'd1);
    read_byte("t2_byte1", 8'h5A, 1'b0);
    read_byte("t2_byte2", 8'hC3, 1'b1);
    #Q;
    check("t2_sda_released", {31'd0, sda_bus}, 32'd1);
    check("t2_state_idle", {24'd0, oState}, 32'h00);
    check("t2_busy", {31'd0, oBusy}, 32'd0);
    bus_stop();
    check("t2_txreq_count", n_txreq, 32'd2);

    // Wrong address: no ACK, back to idle.
    bus_start();
    write_byte("t3_addr_nack", 8'hA2, 1'b1);
    check("t3_state_idle", {24'd0, oState}, 32'h00);
    check("t3_busy", {31'd0, oBusy}, 32'd0);
    bus_stop();
    check("t3_rxq_empty", rxq.size(), 32'd0);

    // Write then repeated START into a read.
    n_txreq = 0;
    bus_start();
    write_byte("t4_waddr_ack", 8'hA0, 1'b0);
    rxq.push_back(8'h11);
    write_byte("t4_data_ack", 8'h11, 1'b0);
    check("t4_rw_write", {31'd0, oRW}, 32'd0);
    txq.push_back(8'h77);
    bus_rstart();
    check("t4_state_addr", {24'd0, oState}, 32'h01);
    write_byte("t4_raddr_ack", 8'hA1, 1'b0);
    check("t4_rw_read", {31'd0, oRW}, 32'd1);
    read_byte("t4_rdata", 8'h77, 1'b1);
    bus_stop();
    check("t4_rx_data", {24'd0, oRx_Data}, 32'h11);
    check("t4_txreq_count", n_txreq, 32'd1);

    // STOP after four data bits aborts the byte; next transaction works.
    bus_start();
    write_byte("t5_addr_ack", 8'hA0, 1'b0);
    partial = 8'hB5;
    for (int i = 7; i >= 4; i--) bit_out(partial[i]);
    bus_stop();
    check("t5_state_idle", {24'd0, oState}, 32'h00);
    check("t5_busy", {31'd0, oBusy}, 32'd0);
    check("t5_sda_released", {31'd0, sda_bus}, 32'd1);
    check("t5_rxq_empty", rxq.size(), 32'd0);
    bus_start();
    write_byte("t5b_addr_ack", 8'hA0, 1'b0);
    rxq.push_back(8'h96);
    write_byte("t5b_data_ack", 8'h96, 1'b0);
    bus_stop();
    check("t5b_rxq_empty", rxq.size(), 32'd0);

    // Reset while the target holds ACK low.
    bus_start();
    write_byte("t6_addr_ack", 8'hA0, 1'b0);
    rxq.push_back(8'h42);
    partial = 8'h42;
    for (int i = 7; i >= 0; i--) bit_out(partial[i]);
    #Q m_oe = 1'b0;
    #Q scl = 1'b1;
    #Q;
    check("t6_ack_driven", {31'd0, sda_bus}, 32'd0);
    iRst = 1'b1;
    @(posedge iClk);
    #1;
    check("t6_sda_released", {31'd0, sda_bus}, 32'd1);
    check("t6_state", {24'd0, oState}, 32'h00);
    check("t6_outs", {20'd0, oRx_Data, oRx_Valid, oTx_Req, oRW, oBusy}, 32'h0);
    iRst = 1'b0;
    #Q scl = 1'b0;
    bus_stop();
    check("t6_rxq_empty", rxq.size(), 32'd0);
    check("t6_state_end", {24'd0, oState}, 32'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/i2c_slave.md
Name: i2c_slave

Overview:
- I2C target (slave) responder for the on-board I2C master FSM.
- Samples external SCL/SDA on the system clock and detects START/STOP.
- Matches a 7-bit address, then receives write bytes or returns read bytes on a byte-wide user interface with per-byte ACK handling.
- Used as a loopback peer for master bring-up on Basys3 and as the front end for register-mapped peripherals.

Parameters:
- SLAVE_ADDR, 7'h50, 7-bit address this target answers to.
- SYNC_STAGES, 2, flip-flop stages in the SCL/SDA input synchronizers (minimum 2).

Ports:
- iClk  input  1  system clock, 100 MHz nominal.
- iRst  input  1  asynchronous, active-high reset.
- iSCL  input  1  bus clock from master; never driven by this block.
- ioSDA  inout  1  bus data, open-drain.
- oRx_Data  output  8  last byte written by master; valid when oRx_Valid=1.
- oRx_Valid  output  1  1-cycle pulse per received write byte.
- iTx_Data  input  8  next byte to return on a read.
- oTx_Req  output  1  1-cycle pulse requesting iTx_Data.
- oRW  output  1  R/W bit of the last matched address (1=read).
- oBusy  output  1  high from matched address until STOP, NACK or mismatch.
- oState  output  8  state code for LED debug.

Behaviour:
- Reset (iRst): state IDLE; all outputs 0; SDA released; shift registers and bit counter cleared. Reset mid-transfer releases SDA on the next iClk edge.
- Input sync: SCL and SDA each pass through SYNC_STAGES flops.
- Edge events (synchronized domain): scl_rise/scl_fall = SCL 0→1 / 1→0. START = SDA 1→0 while SCL=1. STOP = SDA 0→1 while SCL=1.
- SDA output: ioSDA = sda_oe ? 1'b0 : 'z. The block never drives 1.
- sda_oe changes only on the iClk after scl_fall, or on START/STOP/reset (both release it).
- Priority each cycle: reset > STOP > START > scl edges.
- STOP in any state: go to IDLE, release SDA, oBusy=0.
- START in any state (repeated start included): go to ADDR, bit_cnt=0, release SDA.
- States and encodings: IDLE=00, ADDR=01, ADDR_ACK=02, WRITE=10, WRITE_ACK=11, READ=20, READ_ACK=21.
- IDLE: ignore all SCL edges.
- ADDR:
  - On each scl_rise, shift SDA in MSB first; bit_cnt++.
  - After the 8th rise, compare shift[7:1] with SLAVE_ADDR.
  - On match: at the next scl_fall, drive SDA low, latch oRW=shift[0], set oBusy=1, pulse oTx_Req if oRW=1, go to ADDR_ACK.
  - On mismatch: go to IDLE at that scl_fall without driving.
- ADDR_ACK: hold SDA low through the high phase. At the next scl_fall:
  - oRW=0: release SDA, go to WRITE.
  - oRW=1: load iTx_Data into tx_shift, drive bit 7 (oe = ~bit), go to READ.
- WRITE:
  - Shift SDA in on each scl_rise.
  - At the scl_fall after the 8th rise: drive SDA low, set oRx_Data, pulse oRx_Valid, go to WRITE_ACK.
- WRITE_ACK: at the next scl_fall, release SDA, bit_cnt=0, go to WRITE.
- READ:
  - Count bits on each scl_rise.
  - On each scl_fall after rises 1..7, present the next tx_shift bit.
  - At the scl_fall after the 8th rise: release SDA, go to READ_ACK.
- READ_ACK: sample SDA on scl_rise.
  - 0 (ACK): pulse oTx_Req; at the next scl_fall load iTx_Data and drive bit 7; go to READ.
  - 1 (NACK): at the next scl_fall go to IDLE, oBusy=0; SDA stays released.
- iTx_Data rules: sampled only on the scl_fall that starts a read byte. The user has at least one SCL half-period after oTx_Req to set it.
- No clock stretching. No general-call address. No 10-bit addressing.
- Timing: SDA response lags scl_fall by SYNC_STAGES+1 iClk cycles. This is legal because the master changes SDA a quarter period after its SCL falling edge.

Decomposition:
- Shared package i2c_pkg:
  - slave state_t enum with the codes above;
  - I2C_ACK=1'b0 and I2C_NACK=1'b1 constants;
  - the default address constant.
- One sub-module, i2c_sync_edge: SYNC_STAGES synchronizers for SCL/SDA plus scl_rise, scl_fall, start_det and stop_det generation.
- The FSM, shift registers and SDA driver stay in i2c_slave.

Test Plan:
- START, addr 0xA0 (0x50 W), data 0x3C, STOP from the master → slave ACKs both bytes; oRx_Valid pulses once with oRx_Data=0x3C; oBusy 1→0 at STOP.
- START, addr 0xA1 with iTx_Data=0x5A then 0xC3, master ACKs byte 1 and NACKs byte 2, STOP → master receives 0x5A, 0xC3; oTx_Req pulses exactly twice; SDA released after byte 2.
- START, addr 0xA2 (0x51 W) → no ACK (SDA reads 1 at the 9th clock); no oRx_Valid; state returns to IDLE.
- START, 0xA0, data 0x11, repeated START, 0xA1, read one byte 0x77 with NACK, STOP → oRx_Data=0x11, master reads 0x77, oRW goes 0→1.
- STOP injected after the 4th data bit of a write → IDLE, SDA released, no oRx_Valid; the next full transaction completes normally.
- iRst asserted while the slave drives ACK low → ioSDA goes to 'z within 1 iClk; all outputs are 0.
